// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator measurement controller:
// FSM state encoding and phase-counter sizing.
package ro_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // One counter serves both the settle and the window phase, so size it for the longer one.
  function automatic int unsigned phase_w(input int unsigned settle, input int unsigned win);
    int unsigned m;
    m = (settle > win) ? settle : win;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Selected-ring mux, 2-flop synchronizer, rising-edge detect and saturating edge counter.
module ro_edge_counter #(
  parameter int unsigned NUM_RO = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sync_clr,
  input  logic              i_cnt_clr,
  input  logic              i_enable,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [NUM_RO-1:0] i_ro,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_ro_sel;
  logic             w_rise;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  always_comb begin
    w_ro_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (i_sel == SEL_W'(i)) w_ro_sel = i_ro[i];
    end
  end

  // Flushed on a new ring selection so no level from the previous ring survives.
  always_ff @(posedge clk) begin
    if (!rst_n || i_sync_clr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= w_ro_sel;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n || i_cnt_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_enable && w_rise) begin
      if (r_count == CNT_MAX) r_sat   <= 1'b1;
      else                    r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable one ring, settle, count edges over a
// fixed window, then return the count over a valid/ready handshake.
module ro_meas_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RO     = 8,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned WIN_CYC    = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              req_ready,
  output logic [NUM_RO-1:0] ro_enable,
  input  logic [NUM_RO-1:0] ro_signal,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic [SEL_W-1:0]  res_sel,
  output logic              res_sat,
  input  logic              res_ready
);

  localparam int unsigned       PH_W        = phase_w(SETTLE_CYC, WIN_CYC);
  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0]   WIN_LAST    = PH_W'(WIN_CYC - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX     = SEL_W'(NUM_RO - 1);
  localparam logic [NUM_RO-1:0] EN_LSB      = NUM_RO'(1);

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [SEL_W-1:0]  r_sel;
  logic              r_req_ready;
  logic [NUM_RO-1:0] r_ro_enable;
  logic              r_res_valid;
  logic [CNT_W-1:0]  r_res_count;
  logic [SEL_W-1:0]  r_res_sel;
  logic              r_res_sat;

  logic              w_accept;
  logic [SEL_W-1:0]  w_sel_clamp;
  logic [CNT_W-1:0]  w_count;
  logic              w_sat;

  // r_req_ready is high exactly in IDLE, so it doubles as the idle qualifier.
  assign w_accept    = req_valid & r_req_ready;
  assign w_sel_clamp = (req_sel > SEL_MAX) ? SEL_MAX : req_sel;

  ro_edge_counter #(
    .NUM_RO (NUM_RO),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) u_edge_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sync_clr (w_accept),
    .i_cnt_clr  (r_state == ST_SETTLE),
    .i_enable   (r_state == ST_MEASURE),
    .i_sel      (r_sel),
    .i_ro       (ro_signal),
    .o_count    (w_count),
    .o_sat      (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_sel       <= '0;
      r_req_ready <= 1'b1;
      r_ro_enable <= '0;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_res_sel   <= '0;
      r_res_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel       <= w_sel_clamp;
            r_ro_enable <= EN_LSB << w_sel_clamp;
            r_req_ready <= 1'b0;
            r_phase     <= '0;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_phase == SETTLE_LAST) begin
            r_phase <= '0;
            r_state <= ST_MEASURE;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        ST_MEASURE: begin
          // The increment landing on the last window clock is not captured; allowed loss.
          if (r_phase == WIN_LAST) begin
            r_ro_enable <= '0;
            r_res_count <= w_count;
            r_res_sel   <= r_sel;
            r_res_sat   <= w_sat;
            r_res_valid <= 1'b1;
            r_state     <= ST_REPORT;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign ro_enable = r_ro_enable;
  assign res_valid = r_res_valid;
  assign res_count = r_res_count;
  assign res_sel   = r_res_sel;
  assign res_sat   = r_res_sat;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Scoreboard bench: two controllers (8 rings/16-bit counts and 6 rings/4-bit counts)
// driven by behavioural ring models; expected counts come from period arithmetic.
`timescale 1ns/1ps
module tb_ro_meas_ctrl;

  localparam int unsigned WIN    = 1024;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned NA     = 8;
  localparam int unsigned NB     = 6;
  localparam int unsigned TMO    = 4000;

  typedef struct {
    int unsigned sel;
    int unsigned lo;
    int unsigned hi;
    int unsigned sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_req_valid, a_req_ready, a_res_valid, a_res_sat, a_res_ready;
  logic [2:0]  a_req_sel, a_res_sel;
  logic [7:0]  a_en, a_ro;
  logic [15:0] a_res_count;

  logic        b_req_valid, b_req_ready, b_res_valid, b_res_sat, b_res_ready;
  logic [2:0]  b_req_sel, b_res_sel;
  logic [5:0]  b_en, b_ro;
  logic [3:0]  b_res_count;

  int unsigned per_a[NA];
  int unsigned per_b[NB];
  int unsigned ph_a[NA];
  int unsigned ph_b[NB];
  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned rr_mode = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  ro_meas_ctrl #(
    .NUM_RO(NA), .SEL_W(3), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_sel(a_req_sel), .req_ready(a_req_ready),
    .ro_enable(a_en), .ro_signal(a_ro),
    .res_valid(a_res_valid), .res_count(a_res_count), .res_sel(a_res_sel),
    .res_sat(a_res_sat), .res_ready(a_res_ready)
  );

  ro_meas_ctrl #(
    .NUM_RO(NB), .SEL_W(3), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .CNT_W(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_sel(b_req_sel), .req_ready(b_req_ready),
    .ro_enable(b_en), .ro_signal(b_ro),
    .res_valid(b_res_valid), .res_count(b_res_count), .res_sel(b_res_sel),
    .res_sat(b_res_sat), .res_ready(b_res_ready)
  );

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Rising edges in a window of WIN clocks (10 ns) for a ring of period per ns, +-1 for alignment.
  function automatic exp_t model(input int unsigned sel, input int unsigned nro,
                                 input int unsigned per, input int unsigned cw);
    exp_t        e;
    int unsigned num;
    int unsigned mx;
    num   = WIN * 10;
    mx    = (1 << cw) - 1;
    e.sel = (sel >= nro) ? nro - 1 : sel;
    e.lo  = num / per - 1;
    e.hi  = (num + per - 1) / per + 1;
    e.sat = 0;
    if (e.lo > mx) begin
      e.lo  = mx;
      e.hi  = mx;
      e.sat = 1;
    end
    return e;
  endfunction

  // Ring model: each enabled ring toggles every per/2 ns, held low while disabled.
  initial begin
    a_ro = '0;
    b_ro = '0;
    for (int i = 0; i < NA; i++) begin per_a[i] = 80; ph_a[i] = 0; end
    for (int i = 0; i < NB; i++) begin per_b[i] = 80; ph_b[i] = 0; end
    #0.5;
    forever begin
      #1;
      for (int i = 0; i < NA; i++) begin
        if (a_en[i] !== 1'b1) begin a_ro[i] = 1'b0; ph_a[i] = 0; end
        else begin
          ph_a[i]++;
          if (ph_a[i] >= per_a[i] / 2) begin ph_a[i] = 0; a_ro[i] = ~a_ro[i]; end
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (b_en[i] !== 1'b1) begin b_ro[i] = 1'b0; ph_b[i] = 0; end
        else begin
          ph_b[i]++;
          if (ph_b[i] >= per_b[i] / 2) begin ph_b[i] = 0; b_ro[i] = ~b_ro[i]; end
        end
      end
    end
  end

  // Result back-pressure: A random / forced low / forced high by rr_mode, B always random.
  initial begin
    a_res_ready = 1'b0;
    b_res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        1:       a_res_ready = 1'b0;
        2:       a_res_ready = 1'b1;
        default: a_res_ready = ($urandom % 4) != 0;
      endcase
      b_res_ready = ($urandom % 3) != 0;
    end
  end

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("a_enable_onehot0", $countones(a_en), 0, 1);
        if (a_res_valid) begin
          chk("a_res_expected", qa.size(), 1, 1 << 30);
          if (qa.size() > 0) begin
            e = qa[0];
            chk("a_res_sel", a_res_sel, e.sel, e.sel);
            chk("a_res_count", a_res_count, e.lo, e.hi);
            chk("a_res_sat", a_res_sat, e.sat, e.sat);
            if (a_res_ready) void'(qa.pop_front());
          end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("b_enable_onehot0", $countones(b_en), 0, 1);
        if (b_res_valid) begin
          chk("b_res_expected", qb.size(), 1, 1 << 30);
          if (qb.size() > 0) begin
            e = qb[0];
            chk("b_res_sel", b_res_sel, e.sel, e.sel);
            chk("b_res_count", b_res_count, e.lo, e.hi);
            chk("b_res_sat", b_res_sat, e.sat, e.sat);
            if (b_res_ready) void'(qb.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_ready(input bit to_b);
    int unsigned k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(to_b ? b_req_ready : a_req_ready) && k < TMO);
    chk(to_b ? "b_idle_timeout" : "a_idle_timeout", k, 0, TMO - 1);
  endtask

  task automatic measure(input bit to_b, input int unsigned sel, input int unsigned per,
                         input bit expect_res);
    wait_ready(to_b);
    @(posedge clk);
    #1;
    if (to_b) begin
      per_b[(sel >= NB) ? NB - 1 : sel] = per;
      b_req_sel   = 3'(sel);
      b_req_valid = 1'b1;
    end else begin
      per_a[sel]  = per;
      a_req_sel   = 3'(sel);
      a_req_valid = 1'b1;
    end
    @(negedge clk);
    chk(to_b ? "b_req_ready" : "a_req_ready", to_b ? b_req_ready : a_req_ready, 1, 1);
    if (expect_res) begin
      if (to_b) qb.push_back(model(sel, NB, per, 4));
      else      qa.push_back(model(sel, NA, per, 16));
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  initial begin : stim
    int unsigned k;
    rst_n       = 1'b0;
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    a_req_sel   = 3'd3;
    b_req_sel   = 3'd3;
    rr_mode     = 2;
    repeat (3) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_a_enable", a_en, 0, 0);
    chk("rst_a_res_valid", a_res_valid, 0, 0);
    chk("rst_a_req_ready", a_req_ready, 1, 1);
    chk("rst_a_res_count", a_res_count, 0, 0);
    chk("rst_a_res_sel", a_res_sel, 0, 0);
    chk("rst_a_res_sat", a_res_sat, 0, 0);
    chk("rst_b_enable", b_en, 0, 0);
    chk("rst_b_req_ready", b_req_ready, 1, 1);

    // Ring 2 at 80 ns, with B saturating in parallel.
    measure(1'b0, 2, 80, 1'b1);
    measure(1'b1, 1, 40, 1'b1);
    repeat (30) @(negedge clk);
    chk("a_enable_sel2", a_en, 8'h04, 8'h04);
    chk("a_busy_not_ready", a_req_ready, 0, 0);
    chk("b_enable_sel1", b_en, 6'h02, 6'h02);

    // Result held under back-pressure, then released.
    wait_ready(1'b0);
    rr_mode = 1;
    measure(1'b0, 5, 100, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_res_valid && k < TMO);
    chk("a_res_valid_timeout", k, 0, TMO - 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("a_hold_req_ready", a_req_ready, 0, 0);
      chk("a_hold_res_valid", a_res_valid, 1, 1);
      chk("a_hold_enable_off", a_en, 0, 0);
    end
    @(posedge clk);
    #1;
    rr_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("a_after_hs_valid", a_res_valid, 0, 0);
    chk("a_after_hs_ready", a_req_ready, 1, 1);
    measure(1'b0, 3, 60, 1'b1);

    // Back-to-back fast ring 0 then slow ring 7.
    rr_mode = 0;
    measure(1'b0, 0, 24, 1'b1);
    measure(1'b0, 7, 150, 1'b1);

    // Out-of-range select clamps to the last ring of B.
    measure(1'b1, 7, 40, 1'b1);
    repeat (30) @(negedge clk);
    chk("b_enable_clamped", b_en, 6'h20, 6'h20);

    // Abort during MEASURE.
    wait_ready(1'b0);
    wait_ready(1'b1);
    measure(1'b0, 4, 50, 1'b0);
    repeat (SETTLE + 300) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_enable_off", a_en, 0, 0);
    chk("abort_no_valid", a_res_valid, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", a_req_ready, 1, 1);

    for (int r = 0; r < 6; r++) begin
      measure(1'b0, $urandom_range(0, NA - 1), 2 * $urandom_range(12, 100), 1'b1);
      if (r % 2 == 0) measure(1'b1, $urandom_range(0, 7), 2 * $urandom_range(12, 100), 1'b1);
    end

    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 2 * TMO) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k, 0, 2 * TMO - 1);
    chk("a_queue_empty", qa.size(), 0, 0);
    chk("b_queue_empty", qb.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
